// File: rtl/hv_stream_unpack.sv
// hv_stream_unpack: assembles BEATS consecutive BEAT_W-bit stream beats into
// one (DIM+1)-bit hypervector and hands it to the core array via valid/ready.
// Beat k lands in bits [BEAT_W*k +: BEAT_W] (beat 0 = LSBs). The assembly
// register holds beats 0..BEATS-2. The final beat goes straight into the
// output register alongside them, so a full vector flows every BEATS cycles.
`timescale 1ns/1ps

module hv_stream_unpack #(
    parameter int DIM    = 1023,
    parameter int BEAT_W = 256,
    parameter int BEATS  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              src_valid,
    output logic              src_ready,
    input  logic [BEAT_W-1:0] src_data,
    input  logic              src_last,
    output logic              hv_valid,
    input  logic              hv_ready,
    output logic [DIM:0]      hv_data,
    output logic              hv_last,
    output logic              err_short,
    output logic [31:0]       vec_cnt
);

    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int ASM_N = (BEATS > 1) ? BEATS - 1 : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BEATS - 1);

    // The vector must split into a whole number of beats, and at least two.
    generate
        if ((DIM + 1) != BEATS * BEAT_W || BEATS < 2) begin : g_bad_geometry
            $error("hv_stream_unpack: DIM+1 must equal BEATS*BEAT_W with BEATS >= 2");
        end
    endgenerate

    logic [CNT_W-1:0]            beat_cnt_q, beat_cnt_d;
    logic [BEAT_W-1:0]           asm_q [ASM_N];
    logic [BEAT_W*ASM_N-1:0]     asm_flat;
    logic [ASM_N-1:0]            slot_we;
    logic [DIM:0]                hv_data_q;
    logic                        hv_valid_q;
    logic                        hv_last_q;
    logic                        err_short_q;
    logic [31:0]                 vec_cnt_q;

    logic last_slot;
    logic accept;
    logic final_beat;
    logic short_beat;
    logic drain;

    // Only the final beat can stall: it needs the output register free or draining.
    assign last_slot  = (beat_cnt_q == LAST_IDX);
    assign src_ready  = !(last_slot && hv_valid_q && !hv_ready);
    assign accept     = src_valid && src_ready;
    assign final_beat = accept && last_slot;
    assign short_beat = accept && !last_slot && src_last;
    assign drain      = hv_valid_q && hv_ready;

    // Per-slot write enables and flattened view of the assembly register.
    genvar gi;
    generate
        for (gi = 0; gi < ASM_N; gi++) begin : g_slot
            assign slot_we[gi] = accept && !src_last && (beat_cnt_q == CNT_W'(gi));
            assign asm_flat[gi*BEAT_W +: BEAT_W] = asm_q[gi];
        end
    endgenerate

    // Beat position: advance on each accepted beat, restart after final or short-last beat.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (accept) begin
            if (last_slot || src_last) begin
                beat_cnt_d = '0;
            end else begin
                beat_cnt_d = beat_cnt_q + CNT_W'(1);
            end
        end
    end

    // Assembly register and beat counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_q <= '0;
            for (int i = 0; i < ASM_N; i++) begin
                asm_q[i] <= '0;
            end
        end else begin
            beat_cnt_q <= beat_cnt_d;
            for (int i = 0; i < ASM_N; i++) begin
                if (slot_we[i]) begin
                    asm_q[i] <= src_data;
                end
            end
        end
    end

    // Output register: load on final beat (even while draining, so no bubble), clear on drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hv_data_q   <= '0;
            hv_last_q   <= 1'b0;
            hv_valid_q  <= 1'b0;
            err_short_q <= 1'b0;
            vec_cnt_q   <= '0;
        end else begin
            if (final_beat) begin
                hv_data_q  <= {src_data, asm_flat};
                hv_last_q  <= src_last;
                hv_valid_q <= 1'b1;
            end else if (drain) begin
                hv_valid_q <= 1'b0;
            end
            if (drain) begin
                vec_cnt_q <= vec_cnt_q + 32'd1;
            end
            err_short_q <= short_beat;
        end
    end

    assign hv_valid  = hv_valid_q;
    assign hv_data   = hv_data_q;
    assign hv_last   = hv_last_q;
    assign err_short = err_short_q;
    assign vec_cnt   = vec_cnt_q;

endmodule

// File: tb/tb_hv_stream_unpack.sv
// Directed bench for hv_stream_unpack: throughput, backpressure, short packet,
// multi-vector packet, asynchronous reset mid-fill and vector counter wrap.
`timescale 1ns/1ps

module tb_hv_stream_unpack;

    localparam int DIM    = 1023;
    localparam int BEAT_W = 256;
    localparam int BEATS  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              src_valid;
    logic              src_ready;
    logic [BEAT_W-1:0] src_data;
    logic              src_last;
    logic              hv_valid;
    logic              hv_ready;
    logic [DIM:0]      hv_data;
    logic              hv_last;
    logic              err_short;
    logic [31:0]       vec_cnt;

    int vecs = 0;
    int errs = 0;
    logic [31:0] exp_cnt;

    hv_stream_unpack #(.DIM(DIM), .BEAT_W(BEAT_W), .BEATS(BEATS)) dut (
        .clk(clk), .rst_n(rst_n),
        .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data), .src_last(src_last),
        .hv_valid(hv_valid), .hv_ready(hv_ready), .hv_data(hv_data), .hv_last(hv_last),
        .err_short(err_short), .vec_cnt(vec_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [BEAT_W-1:0] rep(input logic [7:0] b);
        return {32{b}};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_slice(input string tag, input int k, input logic [BEAT_W-1:0] exp);
        logic [BEAT_W-1:0] obs;
        obs = hv_data[k*BEAT_W +: BEAT_W];
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s slice%0d observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    // Present one beat for one clock edge, then sample just after the edge.
    task automatic beat(input logic [7:0] b, input logic last);
        src_valid = 1'b1;
        src_data  = rep(b);
        src_last  = last;
        @(posedge clk); #1;
        src_valid = 1'b0;
        src_last  = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; src_valid = 1'b0; src_data = '0; src_last = 1'b0; hv_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_src_ready", 32'(src_ready), 32'd1);
        chk("rst_hv_valid", 32'(hv_valid), 32'd0);
        chk("rst_hv_last", 32'(hv_last), 32'd0);
        chk("rst_err_short", 32'(err_short), 32'd0);
        chk("rst_vec_cnt", vec_cnt, 32'd0);
        chk_slice("rst_hv_data", 0, '0);
        rst_n = 1'b1;
        exp_cnt = 0;

        // Back-to-back with hv_ready=1
        hv_ready = 1'b1;
        beat(8'h11, 1'b0);
        chk("b2b_no_valid_early", 32'(hv_valid), 32'd0);
        beat(8'h22, 1'b0);
        beat(8'h33, 1'b0);
        beat(8'h44, 1'b0);
        chk("b2b_valid", 32'(hv_valid), 32'd1);
        chk("b2b_last", 32'(hv_last), 32'd0);
        chk_slice("b2b_data", 0, rep(8'h11));
        chk_slice("b2b_data", 1, rep(8'h22));
        chk_slice("b2b_data", 2, rep(8'h33));
        chk_slice("b2b_data", 3, rep(8'h44));
        chk("b2b_cnt_before", vec_cnt, 32'd0);
        idle();
        exp_cnt = 1;
        chk("b2b_cnt_after", vec_cnt, exp_cnt);
        chk("b2b_valid_drop", 32'(hv_valid), 32'd0);

        // Backpressure: hv_ready=0, eight beats
        hv_ready = 1'b0;
        beat(8'hA1, 1'b0); beat(8'hA2, 1'b0); beat(8'hA3, 1'b0); beat(8'hA4, 1'b0);
        chk("bp_vec1_valid", 32'(hv_valid), 32'd1);
        chk("bp_ready_b5", 32'(src_ready), 32'd1);
        beat(8'hB1, 1'b0);
        chk("bp_ready_b6", 32'(src_ready), 32'd1);
        beat(8'hB2, 1'b0);
        chk("bp_ready_b7", 32'(src_ready), 32'd1);
        beat(8'hB3, 1'b0);
        src_valid = 1'b1; src_data = rep(8'hB4);
        #1;
        chk("bp_ready_b8", 32'(src_ready), 32'd0);
        @(posedge clk); #1;
        chk("bp_ready_hold", 32'(src_ready), 32'd0);
        chk_slice("bp_hold_data", 0, rep(8'hA1));
        chk_slice("bp_hold_data", 3, rep(8'hA4));
        chk("bp_hold_cnt", vec_cnt, exp_cnt);
        hv_ready = 1'b1;
        #1;
        chk("bp_ready_comb", 32'(src_ready), 32'd1);
        @(posedge clk); #1;
        src_valid = 1'b0;
        exp_cnt = exp_cnt + 1;
        chk("bp_vec2_valid", 32'(hv_valid), 32'd1);
        chk_slice("bp_vec2_data", 0, rep(8'hB1));
        chk_slice("bp_vec2_data", 3, rep(8'hB4));
        chk("bp_cnt1", vec_cnt, exp_cnt);
        idle();
        exp_cnt = exp_cnt + 1;
        chk("bp_cnt2", vec_cnt, exp_cnt);
        chk("bp_valid_drop", 32'(hv_valid), 32'd0);

        // Short packet: last on the second beat
        beat(8'h55, 1'b0);
        beat(8'h66, 1'b1);
        chk("short_err", 32'(err_short), 32'd1);
        chk("short_no_valid", 32'(hv_valid), 32'd0);
        beat(8'hC1, 1'b0);
        chk("short_err_pulse", 32'(err_short), 32'd0);
        beat(8'hC2, 1'b0); beat(8'hC3, 1'b0); beat(8'hC4, 1'b0);
        chk("short_next_valid", 32'(hv_valid), 32'd1);
        chk_slice("short_next", 0, rep(8'hC1));
        chk_slice("short_next", 1, rep(8'hC2));
        chk_slice("short_next", 2, rep(8'hC3));
        chk_slice("short_next", 3, rep(8'hC4));
        idle();
        exp_cnt = exp_cnt + 1;
        chk("short_cnt", vec_cnt, exp_cnt);

        // Sixteen-beat packet, one vector every four cycles
        for (int i = 0; i < 16; i++) begin
            beat(8'(8'h10 + i), (i == 15));
            chk($sformatf("stream_valid_%0d", i), 32'(hv_valid), 32'((i % 4) == 3));
            if ((i % 4) == 3) begin
                chk($sformatf("stream_last_%0d", i), 32'(hv_last), 32'(i == 15));
                chk_slice("stream_data", 0, rep(8'(8'h10 + i - 3)));
                chk_slice("stream_data", 3, rep(8'(8'h10 + i)));
            end
        end
        idle();
        exp_cnt = exp_cnt + 4;
        chk("stream_cnt", vec_cnt, exp_cnt);

        // Reset with a held vector and a partial fill in flight
        hv_ready = 1'b0;
        beat(8'hD1, 1'b0); beat(8'hD2, 1'b0); beat(8'hD3, 1'b0); beat(8'hD4, 1'b0);
        beat(8'hE1, 1'b0); beat(8'hE2, 1'b0);
        chk("rst2_pre_valid", 32'(hv_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst2_hv_valid", 32'(hv_valid), 32'd0);
        chk("rst2_vec_cnt", vec_cnt, 32'd0);
        chk("rst2_src_ready", 32'(src_ready), 32'd1);
        chk("rst2_hv_last", 32'(hv_last), 32'd0);
        chk_slice("rst2_hv_data", 3, '0);
        @(negedge clk);
        rst_n = 1'b1;
        hv_ready = 1'b1;
        idle();
        exp_cnt = 0;
        beat(8'hF1, 1'b0);
        chk("rst2_no_err", 32'(err_short), 32'd0);
        beat(8'hF2, 1'b0); beat(8'hF3, 1'b0); beat(8'hF4, 1'b1);
        chk("rst2_valid", 32'(hv_valid), 32'd1);
        chk("rst2_last", 32'(hv_last), 32'd1);
        chk("rst2_err", 32'(err_short), 32'd0);
        chk_slice("rst2_data", 0, rep(8'hF1));
        chk_slice("rst2_data", 1, rep(8'hF2));
        chk_slice("rst2_data", 2, rep(8'hF3));
        chk_slice("rst2_data", 3, rep(8'hF4));
        idle();
        exp_cnt = exp_cnt + 1;
        chk("rst2_cnt", vec_cnt, exp_cnt);

        // Counter wrap
        force dut.vec_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.vec_cnt_q;
        #1;
        chk("wrap_preload", vec_cnt, 32'hFFFF_FFFF);
        beat(8'h01, 1'b0); beat(8'h02, 1'b0); beat(8'h03, 1'b0); beat(8'h04, 1'b0);
        chk("wrap_valid", 32'(hv_valid), 32'd1);
        idle();
        chk("wrap_cnt", vec_cnt, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
